// File: rtl/multi_pipeline_control_unit.sv
// multi_pipeline_control_unit: decodes a host byte stream into per-bank
// pipeline programming strobes. One bank is the audible front bank. A
// program session fills a back bank, and END_PROGRAM swaps it to the front.
// Optional build macro CTRL_PAYLOAD_CHECKSUM_EN: every payload-carrying
// opcode then takes one trailing XOR checksum byte.
module multi_pipeline_control_unit #(
  parameter int N_BLOCKS       = 256,
  parameter int DATA_WIDTH     = 16,
  parameter int N_PIPELINES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int BLOCK_BYTES   = (N_BLOCKS > 256) ? 2 : 1,
  localparam int DATA_BYTES    = DATA_WIDTH / 8,
  localparam int BW            = $clog2(N_BLOCKS),
  localparam int PW            = ($clog2(N_PIPELINES) < 1) ? 1 : $clog2(N_PIPELINES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  output logic                   next,
  output logic [BW-1:0]          block_target,
  output logic                   reg_target,
  output logic [31:0]            instr_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [23:0]            delay_size_out,
  output logic [23:0]            init_delay_out,
  output logic [N_PIPELINES-1:0] block_instr_write,
  output logic [N_PIPELINES-1:0] block_reg_write,
  output logic [N_PIPELINES-1:0] reg_writes_commit,
  output logic [N_PIPELINES-1:0] alloc_delay,
  output logic [N_PIPELINES-1:0] pipeline_full_reset,
  output logic [N_PIPELINES-1:0] pipeline_enables,
  input  logic [N_PIPELINES-1:0] pipeline_resetting,
  input  logic [N_PIPELINES-1:0] pipeline_regfiles_syncing,
  output logic                   swap_pipelines,
  input  logic                   pipelines_swapping,
  output logic [PW-1:0]          front_pipeline,
  output logic                   set_input_gain,
  output logic                   set_output_gain,
  output logic                   invalid,
  output logic                   timeout,
  output logic [7:0]             control_state
);

  localparam logic [7:0] OP_BEGIN    = 8'h01;
  localparam logic [7:0] OP_WR_INSTR = 8'h02;
  localparam logic [7:0] OP_WR_REG0  = 8'h03;
  localparam logic [7:0] OP_WR_REG1  = 8'h04;
  localparam logic [7:0] OP_ALLOC    = 8'h05;
  localparam logic [7:0] OP_UPD0     = 8'h06;
  localparam logic [7:0] OP_UPD1     = 8'h07;
  localparam logic [7:0] OP_COMMIT   = 8'h08;
  localparam logic [7:0] OP_END      = 8'h09;
  localparam logic [7:0] OP_GAIN_IN  = 8'h0A;
  localparam logic [7:0] OP_GAIN_OUT = 8'h0B;

`ifdef CTRL_PAYLOAD_CHECKSUM_EN
  localparam logic [2:0] CHK_BYTES = 3'd1;
`else
  localparam logic [2:0] CHK_BYTES = 3'd0;
`endif

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [N_PIPELINES-1:0] BANK0 = N_PIPELINES'(1);
  // RESET_WAIT ignores the busy flags for this many cycles so that banks
  // have time to raise pipeline_resetting after a full_reset pulse.
  localparam logic [1:0] HOLD_CYCLES = 2'd2;

  typedef enum logic [2:0] {READY, LISTEN, EXECUTE, SWAP_WAIT, RESET_WAIT} state_t;

  function automatic logic [2:0] payload_len(input logic [7:0] op);
    logic [2:0] n;
    case (op)
      OP_BEGIN:                               n = 3'd1;
      OP_WR_INSTR:                            n = 3'(BLOCK_BYTES + 4);
      OP_WR_REG0, OP_WR_REG1, OP_UPD0, OP_UPD1: n = 3'(BLOCK_BYTES + DATA_BYTES);
      OP_ALLOC:                               n = 3'd6;
      OP_GAIN_IN, OP_GAIN_OUT:                n = 3'(DATA_BYTES);
      default:                                n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [N_PIPELINES-1:0] onehot(input logic [PW-1:0] idx);
    return BANK0 << idx;
  endfunction

  state_t                 state_reg, state_next;
  logic [7:0]             opcode_reg, opcode_next;
  logic [2:0]             count_reg, count_next;
  logic [47:0]            bytes_reg, bytes_next;
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
  logic [7:0]             csum_reg, csum_next;
`endif
  logic                   cooldown_reg, next_reg;
  logic                   programming_reg, programming_next;
  logic [PW-1:0]          target_reg, target_next;
  logic [PW-1:0]          front_reg, front_next;
  logic [N_PIPELINES-1:0] enables_reg, enables_next;
  logic [N_PIPELINES-1:0] full_reset_reg, full_reset_next;
  logic [N_PIPELINES-1:0] instr_wr_reg, instr_wr_next;
  logic [N_PIPELINES-1:0] reg_wr_reg, reg_wr_next;
  logic [N_PIPELINES-1:0] commit_reg, commit_next;
  logic [N_PIPELINES-1:0] alloc_reg, alloc_next;
  logic                   swap_reg, swap_next;
  logic                   gain_in_reg, gain_in_next;
  logic                   gain_out_reg, gain_out_next;
  logic                   invalid_reg, invalid_next;
  logic                   timeout_reg, timeout_next;
  logic [BW-1:0]          block_reg, block_next;
  logic                   reg_sel_reg, reg_sel_next;
  logic [31:0]            instr_reg, instr_next;
  logic [DATA_WIDTH-1:0]  data_reg, data_next;
  logic [23:0]            dsize_reg, dsize_next;
  logic [23:0]            dinit_reg, dinit_next;
  logic [31:0]            timer_reg, timer_next;
  logic [1:0]             hold_reg, hold_next;
  logic                   accept;
  logic                   timer_active;
  logic                   bank_ok;
  logic [N_PIPELINES-1:0] bank_idle;

  // A bank may take block writes only when it is neither resetting nor syncing.
  for (genvar gi = 0; gi < N_PIPELINES; gi++) begin : g_bank_idle
    assign bank_idle[gi] = ~pipeline_resetting[gi] & ~pipeline_regfiles_syncing[gi];
  end

  assign bank_ok = (bytes_reg[7:0] < 8'(N_PIPELINES)) && (bytes_reg[PW-1:0] != front_reg);
  assign timer_active = (state_reg != READY) || programming_reg;

  // Next-state, byte intake, command execution and timeout abort.
  always_comb begin
    state_next       = state_reg;
    opcode_next      = opcode_reg;
    count_next       = count_reg;
    bytes_next       = bytes_reg;
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
    csum_next        = csum_reg;
`endif
    programming_next = programming_reg;
    target_next      = target_reg;
    front_next       = front_reg;
    enables_next     = enables_reg;
    full_reset_next  = '0;
    instr_wr_next    = '0;
    reg_wr_next      = '0;
    commit_next      = '0;
    alloc_next       = '0;
    swap_next        = 1'b0;
    gain_in_next     = 1'b0;
    gain_out_next    = 1'b0;
    invalid_next     = 1'b0;
    timeout_next     = 1'b0;
    block_next       = block_reg;
    reg_sel_next     = reg_sel_reg;
    instr_next       = instr_reg;
    data_next        = data_reg;
    dsize_next       = dsize_reg;
    dinit_next       = dinit_reg;
    hold_next        = hold_reg;
    accept           = 1'b0;

    case (state_reg)
      READY: begin
        if (in_valid && !cooldown_reg) begin
          accept      = 1'b1;
          opcode_next = in_byte;
          bytes_next  = '0;
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
          csum_next   = in_byte;
`endif
          if (payload_len(in_byte) != 3'd0) begin
            count_next = payload_len(in_byte) + CHK_BYTES;
            state_next = LISTEN;
          end else if (in_byte == OP_COMMIT) begin
            commit_next = onehot(front_reg);
          end else if (in_byte == OP_END && programming_reg) begin
            swap_next    = 1'b1;
            commit_next  = onehot(target_reg);
            enables_next = enables_reg | onehot(target_reg);
            state_next   = SWAP_WAIT;
          end else begin
            invalid_next = 1'b1;
          end
        end
      end
      LISTEN: begin
        if (in_valid && !cooldown_reg) begin
          accept = 1'b1;
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
          // The trailing checksum byte folds into the XOR but is not payload.
          csum_next = csum_reg ^ in_byte;
          if (count_reg != 3'd1) bytes_next = {bytes_reg[39:0], in_byte};
`else
          bytes_next = {bytes_reg[39:0], in_byte};
`endif
          count_next = count_reg - 3'd1;
          if (count_reg == 3'd1) state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        state_next = READY;
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
        if (csum_reg != 8'd0) begin
          invalid_next = 1'b1;
        end else
`endif
        case (opcode_reg)
          OP_BEGIN: begin
            if (bank_ok) begin
              if (programming_reg) full_reset_next = onehot(target_reg);
              programming_next = 1'b1;
              target_next      = bytes_reg[PW-1:0];
            end else begin
              invalid_next = 1'b1;
            end
          end
          OP_WR_INSTR, OP_WR_REG0, OP_WR_REG1, OP_ALLOC: begin
            if (!programming_reg) begin
              invalid_next = 1'b1;
            end else if (opcode_reg == OP_ALLOC) begin
              alloc_next = onehot(target_reg);
              dsize_next = bytes_reg[47:24];
              dinit_next = bytes_reg[23:0];
            end else if (!pipelines_swapping && bank_idle[target_reg]) begin
              if (opcode_reg == OP_WR_INSTR) begin
                instr_wr_next = onehot(target_reg);
                block_next    = bytes_reg[32 +: BW];
                instr_next    = bytes_reg[31:0];
              end else begin
                reg_wr_next  = onehot(target_reg);
                block_next   = bytes_reg[DATA_WIDTH +: BW];
                reg_sel_next = (opcode_reg == OP_WR_REG1);
                data_next    = bytes_reg[DATA_WIDTH-1:0];
              end
            end else begin
              state_next = EXECUTE;
            end
          end
          OP_UPD0, OP_UPD1: begin
            // A live update racing a swap could land in the wrong bank: drop it.
            if (pipelines_swapping) begin
              invalid_next = 1'b1;
            end else if (!pipeline_regfiles_syncing[front_reg]) begin
              reg_wr_next  = onehot(front_reg);
              block_next   = bytes_reg[DATA_WIDTH +: BW];
              reg_sel_next = (opcode_reg == OP_UPD1);
              data_next    = bytes_reg[DATA_WIDTH-1:0];
            end else begin
              state_next = EXECUTE;
            end
          end
          OP_GAIN_IN, OP_GAIN_OUT: begin
            gain_in_next  = (opcode_reg == OP_GAIN_IN);
            gain_out_next = (opcode_reg == OP_GAIN_OUT);
            data_next     = bytes_reg[DATA_WIDTH-1:0];
          end
          default: invalid_next = 1'b1;
        endcase
      end
      SWAP_WAIT: begin
        if (!cooldown_reg && !pipelines_swapping) begin
          full_reset_next  = onehot(front_reg);
          enables_next     = enables_reg & ~onehot(front_reg);
          front_next       = target_reg;
          programming_next = 1'b0;
          hold_next        = HOLD_CYCLES;
          state_next       = RESET_WAIT;
        end
      end
      RESET_WAIT: begin
        if (hold_reg != 2'd0) begin
          hold_next = hold_reg - 2'd1;
        end else if (!(|pipeline_resetting)) begin
          enables_next = onehot(front_reg);
          state_next   = READY;
        end
      end
      default: state_next = RESET_WAIT;
    endcase

    // Idle-cycle watchdog: abort the session but leave the front bank alone.
    if (timer_active && !accept && state_next == state_reg) begin
      timer_next = timer_reg + 32'd1;
    end else begin
      timer_next = 32'd0;
    end
    if (timer_active && !accept && state_next == state_reg && timer_reg >= TIMEOUT_LAST) begin
      timeout_next = 1'b1;
      if (programming_reg) begin
        full_reset_next = full_reset_next | onehot(target_reg);
        enables_next    = enables_next & ~onehot(target_reg);
      end
      programming_next = 1'b0;
      hold_next        = HOLD_CYCLES;
      state_next       = RESET_WAIT;
      timer_next       = 32'd0;
    end
  end

  // State and registered outputs; all banks get a full reset out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RESET_WAIT;
      opcode_reg      <= '0;
      count_reg       <= '0;
      bytes_reg       <= '0;
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
      csum_reg        <= '0;
`endif
      cooldown_reg    <= 1'b0;
      next_reg        <= 1'b0;
      programming_reg <= 1'b0;
      target_reg      <= '0;
      front_reg       <= '0;
      enables_reg     <= '0;
      full_reset_reg  <= '1;
      instr_wr_reg    <= '0;
      reg_wr_reg      <= '0;
      commit_reg      <= '0;
      alloc_reg       <= '0;
      swap_reg        <= 1'b0;
      gain_in_reg     <= 1'b0;
      gain_out_reg    <= 1'b0;
      invalid_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
      block_reg       <= '0;
      reg_sel_reg     <= 1'b0;
      instr_reg       <= '0;
      data_reg        <= '0;
      dsize_reg       <= '0;
      dinit_reg       <= '0;
      timer_reg       <= '0;
      hold_reg        <= HOLD_CYCLES;
    end else begin
      state_reg       <= state_next;
      opcode_reg      <= opcode_next;
      count_reg       <= count_next;
      bytes_reg       <= bytes_next;
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
      csum_reg        <= csum_next;
`endif
      cooldown_reg    <= accept;
      next_reg        <= accept;
      programming_reg <= programming_next;
      target_reg      <= target_next;
      front_reg       <= front_next;
      enables_reg     <= enables_next;
      full_reset_reg  <= full_reset_next;
      instr_wr_reg    <= instr_wr_next;
      reg_wr_reg      <= reg_wr_next;
      commit_reg      <= commit_next;
      alloc_reg       <= alloc_next;
      swap_reg        <= swap_next;
      gain_in_reg     <= gain_in_next;
      gain_out_reg    <= gain_out_next;
      invalid_reg     <= invalid_next;
      timeout_reg     <= timeout_next;
      block_reg       <= block_next;
      reg_sel_reg     <= reg_sel_next;
      instr_reg       <= instr_next;
      data_reg        <= data_next;
      dsize_reg       <= dsize_next;
      dinit_reg       <= dinit_next;
      timer_reg       <= timer_next;
      hold_reg        <= hold_next;
    end
  end

  assign next                = next_reg;
  assign block_target        = block_reg;
  assign reg_target          = reg_sel_reg;
  assign instr_out           = instr_reg;
  assign data_out            = data_reg;
  assign delay_size_out      = dsize_reg;
  assign init_delay_out      = dinit_reg;
  assign block_instr_write   = instr_wr_reg;
  assign block_reg_write     = reg_wr_reg;
  assign reg_writes_commit   = commit_reg;
  assign alloc_delay         = alloc_reg;
  assign pipeline_full_reset = full_reset_reg;
  assign pipeline_enables    = enables_reg;
  assign swap_pipelines      = swap_reg;
  assign front_pipeline      = front_reg;
  assign set_input_gain      = gain_in_reg;
  assign set_output_gain     = gain_out_reg;
  assign invalid             = invalid_reg;
  assign timeout             = timeout_reg;
  assign control_state       = {4'd0, timer_active, programming_reg,
                                state_reg != READY, ~&enables_reg};

endmodule

// File: tb/tb_multi_pipeline_control_unit.sv
// Testbench for multi_pipeline_control_unit (4 banks, short timeout).
// Stimulus pushes expected strobe events into a queue; a negedge monitor
// pops and compares every cycle the DUT raises any strobe.
module tb_multi_pipeline_control_unit;
  localparam int NP = 4;
  localparam int NB = 256;
  localparam int DW = 16;
  localparam int TO = 60;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_byte = 8'd0;
  logic          in_valid = 1'b0;
  logic          next;
  logic [7:0]    block_target;
  logic          reg_target;
  logic [31:0]   instr_out;
  logic [DW-1:0] data_out;
  logic [23:0]   delay_size_out, init_delay_out;
  logic [NP-1:0] block_instr_write, block_reg_write, reg_writes_commit, alloc_delay;
  logic [NP-1:0] pipeline_full_reset, pipeline_enables, pipeline_resetting;
  logic [NP-1:0] pipeline_regfiles_syncing = '0;
  logic          swap_pipelines, pipelines_swapping;
  logic [1:0]    front_pipeline;
  logic          set_input_gain, set_output_gain, invalid, timeout;
  logic [7:0]    control_state;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  multi_pipeline_control_unit #(
    .N_BLOCKS(NB), .DATA_WIDTH(DW), .N_PIPELINES(NP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .next(next),
    .block_target(block_target), .reg_target(reg_target), .instr_out(instr_out),
    .data_out(data_out), .delay_size_out(delay_size_out), .init_delay_out(init_delay_out),
    .block_instr_write(block_instr_write), .block_reg_write(block_reg_write),
    .reg_writes_commit(reg_writes_commit), .alloc_delay(alloc_delay),
    .pipeline_full_reset(pipeline_full_reset), .pipeline_enables(pipeline_enables),
    .pipeline_resetting(pipeline_resetting), .pipeline_regfiles_syncing(pipeline_regfiles_syncing),
    .swap_pipelines(swap_pipelines), .pipelines_swapping(pipelines_swapping),
    .front_pipeline(front_pipeline), .set_input_gain(set_input_gain),
    .set_output_gain(set_output_gain), .invalid(invalid), .timeout(timeout),
    .control_state(control_state)
  );

  // Pipeline array model: a full reset keeps the bank busy 4 cycles, a swap takes 10.
  int rst_cnt [NP];
  int swap_cnt = 0;
  always @(posedge clk) begin
    for (int b = 0; b < NP; b++) begin
      if (pipeline_full_reset[b]) rst_cnt[b] <= 4;
      else if (rst_cnt[b] != 0)   rst_cnt[b] <= rst_cnt[b] - 1;
    end
    if (swap_pipelines)     swap_cnt <= 10;
    else if (swap_cnt != 0) swap_cnt <= swap_cnt - 1;
  end
  for (genvar gi = 0; gi < NP; gi++) begin : g_rst
    assign pipeline_resetting[gi] = (rst_cnt[gi] != 0);
  end
  assign pipelines_swapping = (swap_cnt != 0);

  // strobes = {instr_wr, reg_wr, commit, alloc, full_reset, swap, gin, gout, invalid, timeout}
  typedef struct {
    string       name;
    logic [24:0] strobes;
    logic [7:0]  blk;
    logic        rt;
    logic [31:0] instr;
    logic [15:0] data;
    logic [23:0] dsize;
    logic [23:0] dinit;
  } exp_t;
  exp_t exp_q[$];

  task automatic push(input string name, input logic [3:0] iw, input logic [3:0] rw,
                      input logic [3:0] cm, input logic [3:0] al, input logic [3:0] fr,
                      input logic [4:0] flags, input logic [7:0] blk, input logic rt,
                      input logic [31:0] instr, input logic [15:0] data,
                      input logic [23:0] ds, input logic [23:0] di);
    exp_t e;
    e.name = name; e.strobes = {iw, rw, cm, al, fr, flags};
    e.blk = blk; e.rt = rt; e.instr = instr; e.data = data; e.dsize = ds; e.dinit = di;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor.
  exp_t        mon_e;
  logic [24:0] mon_obs;
  bit          mon_ok;
  always @(negedge clk) begin
    if (!reset) begin
      mon_obs = {block_instr_write, block_reg_write, reg_writes_commit, alloc_delay,
                 pipeline_full_reset, swap_pipelines, set_input_gain, set_output_gain,
                 invalid, timeout};
      if (mon_obs != 25'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got strobes %h, required none", mon_obs);
        end else begin
          mon_e = exp_q.pop_front();
          mon_ok = (mon_obs == mon_e.strobes);
          if (mon_e.strobes[24:21] != 0)
            mon_ok = mon_ok && block_target == mon_e.blk && instr_out == mon_e.instr;
          if (mon_e.strobes[20:17] != 0)
            mon_ok = mon_ok && block_target == mon_e.blk && reg_target == mon_e.rt && data_out == mon_e.data;
          if (mon_e.strobes[12:9] != 0)
            mon_ok = mon_ok && delay_size_out == mon_e.dsize && init_delay_out == mon_e.dinit;
          if (mon_e.strobes[3] || mon_e.strobes[2])
            mon_ok = mon_ok && data_out == mon_e.data;
          if (mon_ok) begin
            passes++;
            $display("[%0t] event %s strobes=%h ok", $time, mon_e.name, mon_obs);
          end else begin
            $display("FAIL %s: got strobes=%h blk=%h rt=%b instr=%h data=%h ds=%h di=%h, required strobes=%h blk=%h rt=%b instr=%h data=%h ds=%h di=%h",
                     mon_e.name, mon_obs, block_target, reg_target, instr_out, data_out,
                     delay_size_out, init_delay_out, mon_e.strobes, mon_e.blk, mon_e.rt,
                     mon_e.instr, mon_e.data, mon_e.dsize, mon_e.dinit);
          end
        end
        if (block_reg_write != 0) begin
          checks++;
          if ((block_reg_write & pipeline_regfiles_syncing) == 0) passes++;
          else $display("FAIL reg_write_while_syncing: got write %b syncing %b, required no overlap",
                        block_reg_write, pipeline_regfiles_syncing);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got === req) begin
      passes++;
      $display("[%0t] %s = %0h ok", $time, name, got);
    end else begin
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte = b;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!next && n < 300);
    in_valid = 1'b0;
    check($sformatf("byte_%h_consumed", b), next, 1);
  endtask

  // Sends n bytes of v, most significant byte (the opcode) first.
  task automatic send_cmd(input int n, input logic [63:0] v);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      b = v[8*(n-1-i) +: 8];
      x = x ^ b;
      send_byte(b);
    end
`ifdef CTRL_PAYLOAD_CHECKSUM_EN
    if (n > 1) send_byte(x);
`endif
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (control_state[1] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, control_state[1], 0);
  endtask

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b10000;
  localparam logic [4:0] F_GIN  = 5'b01000;
  localparam logic [4:0] F_INV  = 5'b00010;
  localparam logic [4:0] F_TMO  = 5'b00001;

  initial begin
    int n;
    repeat (3) @(posedge clk);
    push("reset_full_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, F_NONE, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    wait_ready("ready_after_reset");
    check("enables_after_reset", pipeline_enables, 4'b0001);
    check("front_after_reset", front_pipeline, 0);
    check("control_state_idle", control_state, 8'h01);

    send_cmd(2, 64'h01_02);
    wait_ready("ready_after_begin");
    check("control_state_programming", control_state, 8'h0D);

    push("write_instr", 4'b0100, 4'h0, 4'h0, 4'h0, 4'h0, F_NONE, 8'h07, 0, 32'hDEADBEEF, 0, 0, 0);
    send_cmd(6, 64'h02_07_DE_AD_BE_EF);
    push("write_reg1", 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, F_NONE, 8'h05, 1, 0, 16'hABCD, 0, 0);
    send_cmd(4, 64'h04_05_AB_CD);
    push("alloc_delay", 4'h0, 4'h0, 4'h0, 4'b0100, 4'h0, F_NONE, 0, 0, 0, 0, 24'h000100, 24'h000010);
    send_cmd(7, 64'h05_000100_000010);
    push("set_input_gain", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, F_GIN, 0, 0, 0, 16'h55AA, 0, 0);
    send_cmd(3, 64'h0A_55_AA);
    wait_ready("ready_before_commit");
    push("commit_front", 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, F_NONE, 0, 0, 0, 0, 0, 0);
    send_cmd(1, 64'h08);

    push("end_program_swap", 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, F_SWAP, 0, 0, 0, 0, 0, 0);
    push("old_front_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, F_NONE, 0, 0, 0, 0, 0, 0);
    send_cmd(1, 64'h09);
    wait_ready("ready_after_swap");
    check("front_after_swap", front_pipeline, 2);
    check("enables_after_swap", pipeline_enables, 4'b0100);
    check("control_state_after_swap", control_state, 8'h01);

    pipeline_regfiles_syncing = 4'b0100;
    push("update_reg0", 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, F_NONE, 8'h03, 0, 0, 16'h1234, 0, 0);
    send_cmd(4, 64'h06_03_12_34);
    repeat (5) @(posedge clk);
    #1 pipeline_regfiles_syncing = 4'b0000;
    wait_ready("ready_after_update");

    push("bad_opcode", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, F_INV, 0, 0, 0, 0, 0, 0);
    send_cmd(1, 64'h7F);
    push("begin_front_bank", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, F_INV, 0, 0, 0, 0, 0, 0);
    send_cmd(2, 64'h01_02);
    wait_ready("ready_after_bad_begin");
    check("programming_after_bad_begin", control_state[2], 0);
    push("begin_bank_range", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, F_INV, 0, 0, 0, 0, 0, 0);
    send_cmd(2, 64'h01_04);
    push("write_outside_session", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, F_INV, 0, 0, 0, 0, 0, 0);
    send_cmd(6, 64'h02_01_11_22_33_44);
    wait_ready("ready_before_end");
    push("end_outside_session", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, F_INV, 0, 0, 0, 0, 0, 0);
    send_cmd(1, 64'h09);
    wait_ready("ready_after_bad_end");
    check("programming_after_bad_end", control_state[2], 0);

    send_cmd(2, 64'h01_00);
    wait_ready("ready_after_begin0");
    check("programming_bank0", control_state[2], 1);
    push("retarget_reset_prev", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, F_NONE, 0, 0, 0, 0, 0, 0);
    send_cmd(2, 64'h01_01);
    wait_ready("ready_after_retarget");

    push("timeout_abort", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010, F_TMO, 0, 0, 0, 0, 0, 0);
    send_byte(8'h03);
    n = 0;
    while (control_state[2] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("programming_after_timeout", control_state[2], 0);
    wait_ready("ready_after_timeout");
    check("front_after_timeout", front_pipeline, 2);
    check("enables_after_timeout", pipeline_enables, 4'b0100);

    repeat (20) @(posedge clk);
    #1 check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_pipeline_control_unit.md
Name: multi_pipeline_control_unit

Overview:
- Byte-stream command controller managing N_PIPELINES DSP pipeline banks: exactly one front (audible) bank, the rest back banks.
- Decodes host bytes into block instruction/register writes, delay allocations, gain updates and bank swaps.
- Programming targets a back bank chosen per program session; END_PROGRAM promotes it to front.
- Sits between the host byte link and the pipeline array; generalises the two-bank controller.

Parameters:
- N_BLOCKS, 256, blocks per pipeline; BLOCK_BYTES = (N_BLOCKS>256)?2:1
- DATA_WIDTH, 16, register/gain word width, 16 or 24; DATA_BYTES = DATA_WIDTH/8
- N_PIPELINES, 2, pipeline banks, 2..8; PW = max(1,$clog2(N_PIPELINES))
- TIMEOUT_CYCLES, 1000000, idle cycles before an in-progress transaction aborts

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_byte  in  8  host byte
- in_valid  in  1  in_byte valid (level)
- next  out  1  one-cycle pulse: byte consumed
- block_target  out  $clog2(N_BLOCKS)  target block index
- reg_target  out  1  register select 0/1
- instr_out  out  32  instruction word
- data_out  out  DATA_WIDTH  register/gain value
- delay_size_out  out  24  delay buffer size
- init_delay_out  out  24  initial delay
- block_instr_write, block_reg_write, reg_writes_commit, alloc_delay, pipeline_full_reset  out  N_PIPELINES  one-hot per-bank strobes, one cycle
- pipeline_enables  out  N_PIPELINES  level enables
- pipeline_resetting, pipeline_regfiles_syncing  in  N_PIPELINES  per-bank busy
- swap_pipelines  out  1  swap request pulse
- pipelines_swapping  in  1  swap in progress
- front_pipeline  out  PW  current front bank index
- set_input_gain, set_output_gain  out  1  gain strobes (value on data_out)
- invalid  out  1  pulse: bad opcode, bad bank index, or rejected command
- timeout  out  1  pulse on timeout abort
- control_state  out  8  {4'd0, timeout_active, programming, state!=READY, ~&pipeline_enables}

Behaviour:
- Reset (async): state RESET_WAIT; all strobes 0; pipeline_enables 0; pipeline_full_reset all 1s for one cycle after reset release; front_pipeline 0; programming 0; target bank 0; data/instr/delay outputs 0.
- Byte accept: in READY/LISTEN when in_valid && !cooldown. next pulses the following cycle. cooldown=1 for exactly one cycle after each accept; at most one byte per 2 cycles.
- Payload is shifted in MSB-first: bytes_in <= {bytes_in,in_byte}.
- Opcodes (byte count: payload layout):
  - 0x01 BEGIN_PROGRAM (1: bank). Bank must be < N_PIPELINES and != front, else invalid. Sets programming, target.
  - 0x02 WRITE_INSTR (BLOCK_BYTES+4: block, instr).
  - 0x03/0x04 WRITE_REG0/1 (BLOCK_BYTES+DATA_BYTES).
  - 0x05 ALLOC_DELAY (6: size[23:0], init[23:0]).
  - 0x06/0x07 UPDATE_REG0/1 (BLOCK_BYTES+DATA_BYTES), front bank.
  - 0x08 COMMIT (0): reg_writes_commit[front].
  - 0x09 END_PROGRAM (0).
  - 0x0A/0x0B SET_IN/OUT_GAIN (DATA_BYTES).
  - Any other opcode: invalid pulse, stay READY.
- 0x02–0x05 outside programming: payload consumed, then discarded with an invalid pulse.
- States:
  - READY: accept opcode. 0-byte opcodes execute that cycle; otherwise LISTEN.
  - LISTEN: collect bytes; on last byte go EXECUTE.
  - EXECUTE: WRITE_* strobes [target] once !pipelines_swapping && !resetting[target] && !syncing[target].
  - EXECUTE: UPDATE_* strobes [front] once !syncing[front]. If pipelines_swapping, drop the update with an invalid pulse.
  - EXECUTE: ALLOC/GAIN strobe immediately. All branches return to READY.
  - END_PROGRAM (programming=1): swap_pipelines pulse, reg_writes_commit[target], enables[target]=1, go SWAP_WAIT. If programming=0: invalid pulse.
  - SWAP_WAIT: after cooldown and !pipelines_swapping: old front gets full_reset pulse and enable 0; front_pipeline<=target; go RESET_WAIT.
  - RESET_WAIT: when no bank is resetting: enables = onehot(front); go READY.
- Timeout: counter runs while state!=READY or programming. It clears on byte accept or state change. At TIMEOUT_CYCLES-1 idle cycles: timeout pulse, full_reset[target] (if programming), programming 0, state RESET_WAIT. Front bank stays untouched.
- BEGIN_PROGRAM while programming: re-targets the session; the previous target gets a full_reset pulse.
- in_valid while in EXECUTE/SWAP_WAIT/RESET_WAIT: not consumed (next stays low).

Optional Feature:
- Macro CTRL_PAYLOAD_CHECKSUM_EN.
- Defined: every payload-carrying opcode takes one extra trailing byte, equal to the XOR of the opcode and all payload bytes. On mismatch: invalid pulse, no strobe, return to READY.
- Undefined: no trailing byte; byte counts exactly as listed.

Test Plan:
- Reset release -> pipeline_full_reset=all 1s one cycle; enables==onehot(0) after resetting drops; front_pipeline=0.
- N_PIPELINES=4: 0x01,0x02; 0x02,0x07,0xDE,0xAD,0xBE,0xEF -> block_instr_write=4'b0100, block_target=7, instr_out=0xDEADBEEF.
- 0x09 with swap held 10 cycles -> swap pulse; front_pipeline=2 after swapping drops; bank 0 full_reset; enables=4'b0100.
- 0x06,0x03,0x12,0x34 with syncing[front]=1 for 5 cycles -> block_reg_write[front] asserts only after syncing drops; data_out=0x1234.
- 0x01,0x01; 0x03 then silence -> timeout pulse after TIMEOUT_CYCLES; full_reset[1]; programming=0; front bank unchanged.
- Opcode 0x7F -> invalid pulse; 0x01,0x00 (bank==front) -> invalid; programming stays 0.
